// File: rtl/ram_pkg.sv
// ram_pkg
// Shared definitions for the 512x16 RAM port and the block copier that
// drives it: bus widths, RAM depth, read/write encodings, sequencer states.
package ram_pkg;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 16;
    localparam int LEN_W     = 10;
    localparam int MAX_WORDS = 512;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ram512_copier.sv
// ram512_copier
// Sole master on the 512x16 RAM port. Copies (read then write, one word at a
// time, ascending) or fills a block of words, one job at a time.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   start, mode           job request (IDLE only), 0 = copy, 1 = fill
//   src_addr, dst_addr    first source / destination word
//   len                   word count, values above 512 clamp to 512
//   fill_data             word written in fill mode
//   busy, done            job in progress, one-cycle completion pulse
//   mem_en, mem_rw        RAM enable, 1 = write
//   mem_address, mem_in   RAM address and write data (0 while mem_en=0)
//   mem_out               RAM read data, valid same cycle as read request
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | bus quiet, waiting for start
// ST_READ  | copy only: read src+idx, capture word at the edge
// ST_WRITE | write dst+idx, advance idx at the edge
// ST_DONE  | one-cycle done pulse, bus quiet, return to IDLE
module ram512_copier
    import ram_pkg::*;
#(
    parameter int ADDR_W = ram_pkg::ADDR_W,
    parameter int DATA_W = ram_pkg::DATA_W,
    parameter int LEN_W  = ram_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_mode;
    logic [ADDR_W-1:0]   r_src;
    logic [ADDR_W-1:0]   r_dst;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_fill;
    logic [DATA_W-1:0]   r_data;

    logic                w_accept;
    logic                w_last;
    logic [ADDR_W-1:0]   w_src_addr;
    logic [ADDR_W-1:0]   w_dst_addr;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_last     = (r_idx == (r_len - LEN_W'(1)));
    // Truncation to ADDR_W bits gives the 511 -> 0 wrap.
    assign w_src_addr = r_src + r_idx[ADDR_W-1:0];
    assign w_dst_addr = r_dst + r_idx[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= 1'b0;
            r_src  <= '0;
            r_dst  <= '0;
            r_len  <= '0;
            r_idx  <= '0;
            r_fill <= '0;
            r_data <= '0;
        end else begin
            if (w_accept) begin
                r_mode <= mode;
                r_src  <= src_addr;
                r_dst  <= dst_addr;
                r_len  <= (len > MAX_LEN) ? MAX_LEN : len;
                r_idx  <= '0;
                r_fill <= fill_data;
            end
            if (r_state == ST_READ) begin
                r_data <= mem_out;
            end
            if (r_state == ST_WRITE) begin
                r_idx <= r_idx + LEN_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        mem_en       = 1'b0;
        mem_rw       = RW_READ;
        mem_address  = '0;
        mem_in       = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        w_state_next = ST_DONE;
                    end else if (mode) begin
                        w_state_next = ST_WRITE;
                    end else begin
                        w_state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                busy         = 1'b1;
                mem_en       = 1'b1;
                mem_rw       = RW_READ;
                mem_address  = w_src_addr;
                w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                busy        = 1'b1;
                mem_en      = 1'b1;
                mem_rw      = RW_WRITE;
                mem_address = w_dst_addr;
                mem_in      = r_mode ? r_fill : r_data;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else if (r_mode) begin
                    w_state_next = ST_WRITE;
                end else begin
                    w_state_next = ST_READ;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram512_copier.sv
// tb_ram512_copier
// Drives ram512_copier against a behavioural 512x16 RAM held in this bench.
// Expected values are hand-computed per directed job.
module tb_ram512_copier;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [8:0]  src_addr;
    logic [8:0]  dst_addr;
    logic [9:0]  len;
    logic [15:0] fill_data;
    logic        busy;
    logic        done;
    logic        mem_en;
    logic        mem_rw;
    logic [8:0]  mem_address;
    logic [15:0] mem_in;
    logic [15:0] mem_out;

    logic [15:0] ram [0:511];
    logic        pl_we;
    logic [8:0]  pl_addr;
    logic [15:0] pl_data;

    int n_checks;
    int n_fail;

    ram512_copier dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
        .fill_data   (fill_data),
        .busy        (busy),
        .done        (done),
        .mem_en      (mem_en),
        .mem_rw      (mem_rw),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_out     (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM512 model: combinational read, write at rising edge. The preload
    // port is only used while the copier is idle.
    assign mem_out = (mem_en && !mem_rw) ? ram[mem_address] : 16'h0000;

    always @(posedge clk) begin
        if (mem_en && mem_rw) begin
            ram[mem_address] <= mem_in;
        end else if (pl_we) begin
            ram[pl_addr] <= pl_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [8:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk);
        #1;
        pl_we = 1'b0;
    endtask

    // Launch a job at a negedge, accept at the following edge k, then count
    // cycles after k until done is seen. cycles = N means done in cycle k+N.
    // pulse_at > 0 drives a conflicting start during that cycle.
    task automatic run_job(input logic m, input logic [8:0] s, input logic [8:0] d,
                           input logic [9:0] l, input logic [15:0] f, input int pulse_at,
                           output int cycles, output int writes, output int en_cycles,
                           output int busy_seen, output int en_in_done);
        int n;
        cycles = 0; writes = 0; en_cycles = 0; busy_seen = 0; en_in_done = 0;
        @(negedge clk);
        mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (start) start = 1'b0;
            if (mem_en) en_cycles++;
            if (mem_en && mem_rw) writes++;
            if (busy) busy_seen = 1;
            if (done) begin
                if (mem_en) en_in_done = 1;
                break;
            end
            if (n == pulse_at) begin
                mode = ~m; src_addr = 9'h1F0; dst_addr = 9'h030; len = 10'd7;
                fill_data = 16'hDEAD; start = 1'b1;
            end
        end
        start = 1'b0;
        cycles = n;
        if (n >= 2000) chk("job_timeout", 32'(n), 32'd0);
    endtask

    int cyc, wr, en, bs, ed;

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_data = '0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_en", 32'(mem_en), 32'd0);
        chk("rst_rw", 32'(mem_rw), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_in", 32'(mem_in), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill 4 words at 0x010.
        preload(9'h014, 16'h1234);
        run_job(1'b1, 9'h000, 9'h010, 10'd4, 16'hA5A5, 0, cyc, wr, en, bs, ed);
        chk("fill_cycles", 32'(cyc), 32'd5);
        chk("fill_writes", 32'(wr), 32'd4);
        chk("fill_w0", 32'(ram[9'h010]), 32'hA5A5);
        chk("fill_w3", 32'(ram[9'h013]), 32'hA5A5);
        chk("fill_next", 32'(ram[9'h014]), 32'h1234);

        // Copy 3 words 0x000 -> 0x100.
        preload(9'h000, 16'h1111);
        preload(9'h001, 16'h2222);
        preload(9'h002, 16'h3333);
        preload(9'h103, 16'h4444);
        run_job(1'b0, 9'h000, 9'h100, 10'd3, 16'h0000, 0, cyc, wr, en, bs, ed);
        chk("copy_cycles", 32'(cyc), 32'd7);
        chk("copy_en_cycles", 32'(en), 32'd6);
        chk("copy_writes", 32'(wr), 32'd3);
        chk("copy_en_done", 32'(ed), 32'd0);
        chk("copy_w0", 32'(ram[9'h100]), 32'h1111);
        chk("copy_w1", 32'(ram[9'h101]), 32'h2222);
        chk("copy_w2", 32'(ram[9'h102]), 32'h3333);
        chk("copy_past", 32'(ram[9'h103]), 32'h4444);

        // Wrap-around fill.
        run_job(1'b1, 9'h000, 9'h1FE, 10'd4, 16'hBEEF, 0, cyc, wr, en, bs, ed);
        chk("wrap_cycles", 32'(cyc), 32'd5);
        chk("wrap_1fe", 32'(ram[9'h1FE]), 32'hBEEF);
        chk("wrap_1ff", 32'(ram[9'h1FF]), 32'hBEEF);
        chk("wrap_000", 32'(ram[9'h000]), 32'hBEEF);
        chk("wrap_001", 32'(ram[9'h001]), 32'hBEEF);
        chk("wrap_002", 32'(ram[9'h002]), 32'h3333);

        // Overlapping copy with dst > src propagates the first word.
        preload(9'h050, 16'h0A0A);
        preload(9'h051, 16'h0B0B);
        preload(9'h052, 16'h0C0C);
        run_job(1'b0, 9'h050, 9'h051, 10'd2, 16'h0000, 0, cyc, wr, en, bs, ed);
        chk("ovl_51", 32'(ram[9'h051]), 32'h0A0A);
        chk("ovl_52", 32'(ram[9'h052]), 32'h0A0A);

        // len = 0: immediate done, no bus activity.
        run_job(1'b1, 9'h000, 9'h020, 10'd0, 16'hFFFF, 0, cyc, wr, en, bs, ed);
        chk("len0_cycles", 32'(cyc), 32'd1);
        chk("len0_en", 32'(en), 32'd0);
        chk("len0_busy", 32'(bs), 32'd0);

        // len = 600 clamps to 512.
        run_job(1'b1, 9'h000, 9'h080, 10'd600, 16'h0F0F, 0, cyc, wr, en, bs, ed);
        chk("len600_cycles", 32'(cyc), 32'd513);
        chk("len600_writes", 32'(wr), 32'd512);
        chk("len600_07f", 32'(ram[9'h07F]), 32'h0F0F);
        chk("len600_100", 32'(ram[9'h100]), 32'h0F0F);

        // start while busy is ignored.
        run_job(1'b1, 9'h000, 9'h020, 10'd3, 16'hC3C3, 2, cyc, wr, en, bs, ed);
        chk("busy_cycles", 32'(cyc), 32'd4);
        chk("busy_w0", 32'(ram[9'h020]), 32'hC3C3);
        chk("busy_w2", 32'(ram[9'h022]), 32'hC3C3);
        chk("busy_w3", 32'(ram[9'h023]), 32'h0F0F);
        chk("busy_other", 32'(ram[9'h030]), 32'h0F0F);
        @(negedge clk);
        chk("busy_idle_after", 32'(busy), 32'd0);

        // Reset during WRITE of word 2 of a 5-word fill.
        for (int i = 0; i < 5; i++) preload(9'(9'h040 + i), 16'(16'h1000 + i));
        @(negedge clk);
        mode = 1'b1; dst_addr = 9'h040; len = 10'd5; fill_data = 16'h7777; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_addr_pre", 32'(mem_address), 32'h042);
        rst = 1'b1;
        #1;
        chk("rstmid_en", 32'(mem_en), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_addr", 32'(mem_address), 32'd0);
        chk("rstmid_in", 32'(mem_in), 32'd0);
        chk("rstmid_rw", 32'(mem_rw), 32'd0);
        ed = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) ed = 1;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) ed = 1;
        end
        chk("rstmid_no_done", 32'(ed), 32'd0);
        chk("rstmid_w0", 32'(ram[9'h040]), 32'h7777);
        chk("rstmid_w1", 32'(ram[9'h041]), 32'h7777);
        chk("rstmid_w2", 32'(ram[9'h042]), 32'h1002);
        chk("rstmid_w3", 32'(ram[9'h043]), 32'h1003);
        chk("rstmid_w4", 32'(ram[9'h044]), 32'h1004);
        run_job(1'b1, 9'h000, 9'h044, 10'd1, 16'h9999, 0, cyc, wr, en, bs, ed);
        chk("after_rst_cycles", 32'(cyc), 32'd2);
        chk("after_rst_w", 32'(ram[9'h044]), 32'h9999);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
